// File: rtl/vm2002_if.sv
// Front-end/back-end bus of the vending-machine core: user coins and selection,
// supplier loads, and the registered dispenser/display outputs.
interface vm2002_if;
  logic [1:0]  coins;
  logic [2:0]  buttons;
  logic        select;
  logic        valid;
  logic [2:0]  item;
  logic [3:0]  count;
  logic [7:0]  cost;
  logic [2:0]  product;
  logic [15:0] balance;
  logic [7:0]  info;
  logic [2:0]  status;

  modport master (
    output coins, buttons, select, valid, item, count, cost,
    input  product, balance, info, status
  );
  modport slave (
    input  coins, buttons, select, valid, item, count, cost,
    output product, balance, info, status
  );
endinterface

// File: rtl/vm2002.sv
// Vending-machine controller core: 8-slot inventory, coin credit, dispense/change.
// Optional 512-cycle inactivity refund is built when VM2002_TIMEOUT_EN is defined.
module vm2002 (
  input  logic      clk,
  input  logic      hrst,
  input  logic      srst,
  vm2002_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_REFUND} state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_COLLECT  = 3'd1;
  localparam logic [2:0] ST_DISPENSE = 3'd2;
  localparam logic [2:0] ST_REFUND   = 3'd3;
  localparam logic [2:0] ST_SOLDOUT  = 3'd4;
  localparam logic [2:0] ST_INSUFF   = 3'd5;

  state_t          r_state;
  logic [7:0][3:0] r_cnt;
  logic [7:0][7:0] r_cost;
  logic [15:0]     r_amount;
  logic [2:0]      r_product;
  logic [15:0]     r_balance;
  logic [7:0]      r_info;
  logic [2:0]      r_status;
`ifdef VM2002_TIMEOUT_EN
  logic [8:0]      r_timer;
`endif

  logic [15:0] w_coin;
  logic [16:0] w_sum;
  logic [15:0] w_amt;
  logic [2:0]  w_sel;

  // Credit including this cycle's coin, saturated at 16'hFFFF
  always_comb begin
    w_coin = 16'd0;
    case (bus.coins)
      2'b01:   w_coin = 16'd5;
      2'b10:   w_coin = 16'd10;
      2'b11:   w_coin = 16'd25;
      default: w_coin = 16'd0;
    endcase
    w_sum = {1'b0, r_amount} + {1'b0, w_coin};
    w_amt = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    w_sel = bus.buttons;
  end

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cost    <= '0;
      r_amount  <= 16'd0;
      r_product <= 3'd0;
      r_balance <= 16'd0;
      r_info    <= 8'd0;
      r_status  <= ST_IDLE;
`ifdef VM2002_TIMEOUT_EN
      r_timer   <= 9'h1FF;
`endif
    end else if (srst) begin
      r_state   <= S_IDLE;
      r_amount  <= 16'd0;
      r_product <= 3'd0;
      r_balance <= 16'd0;
      r_info    <= 8'd0;
      r_status  <= ST_IDLE;
`ifdef VM2002_TIMEOUT_EN
      r_timer   <= 9'h1FF;
`endif
    end else begin
      r_info    <= r_cost[w_sel];
      r_product <= 3'd0;
      case (r_state)
        S_IDLE: begin
          r_balance <= 16'd0;
          r_status  <= ST_IDLE;
          if (bus.valid) begin
            r_cnt[bus.item]  <= bus.count;
            r_cost[bus.item] <= bus.cost;
          end
          if (w_coin != 16'd0) begin
            r_state   <= S_COLLECT;
            r_status  <= ST_COLLECT;
            r_amount  <= w_coin;
            r_balance <= w_coin;
`ifdef VM2002_TIMEOUT_EN
            r_timer   <= 9'h1FF;
`endif
          end
        end
        S_COLLECT: begin
          if (bus.select) begin
`ifdef VM2002_TIMEOUT_EN
            r_timer <= 9'h1FF;
`endif
            if (r_cnt[w_sel] == 4'd0) begin
              r_status  <= ST_SOLDOUT;
              r_amount  <= w_amt;
              r_balance <= w_amt;
            end else if (w_amt < {8'd0, r_cost[w_sel]}) begin
              r_status  <= ST_INSUFF;
              r_amount  <= w_amt;
              r_balance <= w_amt;
            end else begin
              r_state      <= S_DISPENSE;
              r_status     <= ST_DISPENSE;
              r_product    <= w_sel;
              r_cnt[w_sel] <= r_cnt[w_sel] - 4'd1;
              r_balance    <= w_amt - {8'd0, r_cost[w_sel]};
              r_amount     <= 16'd0;
            end
          end else if (w_coin != 16'd0) begin
            r_status  <= ST_COLLECT;
            r_amount  <= w_amt;
            r_balance <= w_amt;
`ifdef VM2002_TIMEOUT_EN
            r_timer   <= 9'h1FF;
`endif
          end
`ifdef VM2002_TIMEOUT_EN
          else if (r_timer == 9'd0) begin
            r_state   <= S_REFUND;
            r_status  <= ST_REFUND;
            r_balance <= r_amount;
            r_amount  <= 16'd0;
          end else begin
            r_timer   <= r_timer - 9'd1;
            r_status  <= ST_COLLECT;
            r_balance <= r_amount;
          end
`else
          else begin
            r_status  <= ST_COLLECT;
            r_balance <= r_amount;
          end
`endif
        end
        default: begin
          // DISPENSE/REFUND hold for one cycle; coins and loads here are dropped
          r_state   <= S_IDLE;
          r_status  <= ST_IDLE;
          r_balance <= 16'd0;
        end
      endcase
    end
  end

  assign bus.product = r_product;
  assign bus.balance = r_balance;
  assign bus.info    = r_info;
  assign bus.status  = r_status;
endmodule

// File: tb/tb_vm2002.sv
// Directed bench for vm2002: load, purchase, insufficient, sold-out, saturation,
// ignored loads/selects, resets, and the refund timer when VM2002_TIMEOUT_EN is set.
module tb_vm2002;
  logic clk = 1'b0;
  logic hrst, srst;
  int   checks = 0;
  int   fails  = 0;

  vm2002_if bus();
  vm2002 dut (.clk(clk), .hrst(hrst), .srst(srst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.coins = 2'd0; bus.select = 1'b0; bus.valid = 1'b0;
  endtask

  task automatic test_reset();
    hrst = 1'b1; srst = 1'b0; idle_in();
    bus.buttons = 3'd0; bus.item = 3'd0; bus.count = 4'd0; bus.cost = 8'd0;
    #2;
    checks++;
    if ({bus.status, bus.balance, bus.product, bus.info} !== {3'd0, 16'd0, 3'd0, 8'd0}) begin
      fails++; $display("FAIL reset got st=%0d bal=%0d prod=%0d info=%0d exp all 0", bus.status, bus.balance, bus.product, bus.info);
    end
    hrst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    // load slot 2 twice: overwrite, not accumulate, so count stays 3
    bus.valid = 1'b1; bus.item = 3'd2; bus.count = 4'd3; bus.cost = 8'd30;
    tick(); tick();
    bus.valid = 1'b0; bus.buttons = 3'd2;
    tick();
    checks++;
    if (bus.info !== 8'd30) begin fails++; $display("FAIL load_info got=%0d exp=30", bus.info); end
  endtask

  task automatic test_purchase();
    bus.coins = 2'd3; tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd1, 16'd25}) begin fails++; $display("FAIL buy_c1 got st=%0d bal=%0d exp 1/25", bus.status, bus.balance); end
    bus.coins = 2'd2; tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd1, 16'd35}) begin fails++; $display("FAIL buy_c2 got st=%0d bal=%0d exp 1/35", bus.status, bus.balance); end
    bus.coins = 2'd0; bus.select = 1'b1; bus.buttons = 3'd2; tick();
    checks++;
    if ({bus.status, bus.balance, bus.product} !== {3'd2, 16'd5, 3'd2}) begin
      fails++; $display("FAIL buy_disp got st=%0d bal=%0d prod=%0d exp 2/5/2", bus.status, bus.balance, bus.product);
    end
    bus.select = 1'b0; bus.coins = 2'd3; tick();  // coin during DISPENSE dropped
    checks++;
    if ({bus.status, bus.balance, bus.product} !== {3'd0, 16'd0, 3'd0}) begin
      fails++; $display("FAIL buy_idle got st=%0d bal=%0d prod=%0d exp 0/0/0", bus.status, bus.balance, bus.product);
    end
    bus.coins = 2'd0; tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd0, 16'd0}) begin fails++; $display("FAIL disp_coin_drop got st=%0d bal=%0d exp 0/0", bus.status, bus.balance); end
  endtask

  task automatic test_insufficient();
    bus.coins = 2'd3; tick();
    bus.coins = 2'd0; bus.select = 1'b1; bus.buttons = 3'd2; tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd5, 16'd25}) begin fails++; $display("FAIL insuff got st=%0d bal=%0d exp 5/25", bus.status, bus.balance); end
    bus.select = 1'b0; tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd1, 16'd25}) begin fails++; $display("FAIL insuff_back got st=%0d bal=%0d exp 1/25", bus.status, bus.balance); end
    bus.coins = 2'd1; bus.select = 1'b1; tick();
    checks++;
    if ({bus.status, bus.balance, bus.product} !== {3'd2, 16'd0, 3'd2}) begin
      fails++; $display("FAIL insuff_coin_sel got st=%0d bal=%0d prod=%0d exp 2/0/2", bus.status, bus.balance, bus.product);
    end
    idle_in(); tick();
    // last unit of slot 2: 50 - 30 = 20 change
    bus.coins = 2'd3; tick(); tick();
    bus.coins = 2'd0; bus.select = 1'b1; tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd2, 16'd20}) begin fails++; $display("FAIL last_unit got st=%0d bal=%0d exp 2/20", bus.status, bus.balance); end
    bus.select = 1'b0; tick();
  endtask

  task automatic test_sold_out();
    bus.coins = 2'd2; tick();
    bus.coins = 2'd0; bus.select = 1'b1; bus.buttons = 3'd2; tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd4, 16'd10}) begin fails++; $display("FAIL soldout_s2 got st=%0d bal=%0d exp 4/10", bus.status, bus.balance); end
    bus.buttons = 3'd5; tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd4, 16'd10}) begin fails++; $display("FAIL soldout_s5 got st=%0d bal=%0d exp 4/10", bus.status, bus.balance); end
    bus.select = 1'b0; tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd1, 16'd10}) begin fails++; $display("FAIL soldout_back got st=%0d bal=%0d exp 1/10", bus.status, bus.balance); end
  endtask

  task automatic test_srst();
    // supplier load while collecting must be ignored
    bus.valid = 1'b1; bus.item = 3'd5; bus.count = 4'd9; bus.cost = 8'd44; tick();
    bus.valid = 1'b0; srst = 1'b1; bus.coins = 2'd3; bus.select = 1'b1; tick();
    checks++;
    if ({bus.status, bus.balance, bus.info} !== {3'd0, 16'd0, 8'd0}) begin
      fails++; $display("FAIL srst got st=%0d bal=%0d info=%0d exp 0/0/0", bus.status, bus.balance, bus.info);
    end
    srst = 1'b0; idle_in(); bus.buttons = 3'd2; tick();
    checks++;
    if (bus.info !== 8'd30) begin fails++; $display("FAIL srst_inv got=%0d exp=30", bus.info); end
    bus.buttons = 3'd5; tick();
    checks++;
    if (bus.info !== 8'd0) begin fails++; $display("FAIL load_ignored got=%0d exp=0", bus.info); end
    bus.select = 1'b1; bus.buttons = 3'd2; tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd0, 16'd0}) begin fails++; $display("FAIL idle_select got st=%0d bal=%0d exp 0/0", bus.status, bus.balance); end
    bus.select = 1'b0; tick();
  endtask

  task automatic test_saturate();
    bus.coins = 2'd3;
    repeat (2700) tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd1, 16'hFFFF}) begin fails++; $display("FAIL saturate got st=%0d bal=%0h exp 1/ffff", bus.status, bus.balance); end
    srst = 1'b1; idle_in(); tick(); srst = 1'b0;
  endtask

  task automatic test_reload();
    bus.valid = 1'b1; bus.item = 3'd2; bus.count = 4'd1; bus.cost = 8'd7; tick();
    bus.valid = 1'b0; bus.buttons = 3'd2; tick();
    checks++;
    if (bus.info !== 8'd7) begin fails++; $display("FAIL reload_info got=%0d exp=7", bus.info); end
    bus.coins = 2'd2; tick();
    bus.coins = 2'd0; bus.select = 1'b1; tick();
    checks++;
    if ({bus.status, bus.balance, bus.product} !== {3'd2, 16'd3, 3'd2}) begin
      fails++; $display("FAIL reload_buy got st=%0d bal=%0d prod=%0d exp 2/3/2", bus.status, bus.balance, bus.product);
    end
    bus.select = 1'b0; tick();
  endtask

  task automatic test_hrst();
    bus.coins = 2'd2; tick();
    bus.coins = 2'd0;
    hrst = 1'b1; #2;
    checks++;
    if ({bus.status, bus.balance, bus.product, bus.info} !== {3'd0, 16'd0, 3'd0, 8'd0}) begin
      fails++; $display("FAIL hrst got st=%0d bal=%0d prod=%0d info=%0d exp all 0", bus.status, bus.balance, bus.product, bus.info);
    end
    hrst = 1'b0; bus.buttons = 3'd2; tick();
    checks++;
    if (bus.info !== 8'd0) begin fails++; $display("FAIL hrst_inv got=%0d exp=0", bus.info); end
  endtask

`ifdef VM2002_TIMEOUT_EN
  task automatic test_timeout();
    bus.coins = 2'd2; tick();
    bus.coins = 2'd0;
    repeat (511) tick();
    checks++;
    if (bus.status !== 3'd1) begin fails++; $display("FAIL to_early got st=%0d exp=1", bus.status); end
    tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd3, 16'd10}) begin fails++; $display("FAIL to_refund got st=%0d bal=%0d exp 3/10", bus.status, bus.balance); end
    tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd0, 16'd0}) begin fails++; $display("FAIL to_idle got st=%0d bal=%0d exp 0/0", bus.status, bus.balance); end
    bus.coins = 2'd2; tick();
    bus.coins = 2'd0; repeat (499) tick();
    bus.coins = 2'd1; tick();
    bus.coins = 2'd0; repeat (511) tick();
    checks++;
    if (bus.status !== 3'd1) begin fails++; $display("FAIL to_restart got st=%0d exp=1", bus.status); end
    tick();
    checks++;
    if ({bus.status, bus.balance} !== {3'd3, 16'd15}) begin fails++; $display("FAIL to_refund2 got st=%0d bal=%0d exp 3/15", bus.status, bus.balance); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_purchase();
    test_insufficient();
    test_sold_out();
    test_srst();
    test_saturate();
    test_reload();
`ifdef VM2002_TIMEOUT_EN
    test_timeout();
`endif
    test_hrst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/vm2002.md
# vm2002

The vm2002 block is the vending-machine controller core. It stores an 8-slot inventory that a supplier loads, and accumulates coin credit from the user. When the user selects a slot, it dispenses the product and returns change. If the user stops interacting for 512 clocks, it refunds the credit. It sits between the user/supplier front-end and the dispenser/display back-end, and all of its outputs are registered.

## Interface
No parameters. Ports:
- clk  in  1  clock; all logic on rising edge.
- hrst  in  1  hard reset, asynchronous, active-high; clears everything including inventory.
- srst  in  1  soft reset, synchronous, active-high; clears transaction state, inventory kept.
- coins  in  2  per-cycle coin: 00 none, 01 = 5, 10 = 10, 11 = 25.
- buttons  in  3  slot index chosen by user.
- select  in  1  one-cycle strobe that commits purchase of slot `buttons`.
- valid  in  1  supplier load strobe.
- item  in  3  supplier slot index.
- count  in  4  supplier quantity for slot.
- cost  in  8  supplier unit price for slot.
- product  out  3  dispensed slot index; valid only while status == DISPENSE, else 0.
- balance  out  16  credit, change or refund amount (see Operation).
- info  out  8  price of slot `buttons`, registered.
- status  out  3  0 IDLE, 1 COLLECT, 2 DISPENSE, 3 REFUND, 4 SOLD_OUT, 5 INSUFFICIENT.

## Operation
Storage:
- Inventory is 8 × {count[3:0], cost[7:0]}.
- amount is a 16-bit credit register. Coin additions saturate at 16'hFFFF.

Supplier load:
- valid = 1 in IDLE overwrites count[item] and cost[item]. It does not add to the existing count.
- valid in any other state is ignored.

State machine:
- IDLE: a nonzero coin sets amount to the coin value and moves to COLLECT. select with zero credit is ignored.
- COLLECT: each nonzero coin adds to amount and reloads the timer. On select, slot s = buttons and the same-cycle coin is already included in the compare:
  - count[s] == 0: status SOLD_OUT for 1 cycle, stay in COLLECT, credit kept.
  - amount < cost[s]: status INSUFFICIENT for 1 cycle, stay in COLLECT.
  - otherwise: go to DISPENSE. product = s, count[s] decrements, balance = amount − cost[s], amount = 0.
- DISPENSE: lasts one cycle, then IDLE.
- Timeout: the 9-bit down-counter expires after 512 cycles in COLLECT with no coin and no select. The block then goes to REFUND: balance = amount, amount = 0.
- REFUND: lasts one cycle, then IDLE.
- select also reloads the timer.

Outputs:
- balance is 0 in IDLE and equals amount in COLLECT, SOLD_OUT and INSUFFICIENT.
- info = cost[buttons], sampled each cycle.

## Timing
- hrst (asynchronous): state IDLE, product 0, balance 0, info 0, status IDLE, amount 0, timer 511, all inventory 0.
- srst (synchronous, next edge): same as hrst except inventory is retained. Pending credit is discarded with no refund.
- srst takes priority over all inputs in the same cycle.
- One-cycle latency throughout: inputs sampled at edge N appear on the outputs after edge N.
- The timer starts at 511 on entry to COLLECT. The REFUND status appears on the 512th idle cycle.
- A coin in the same cycle as a DISPENSE or REFUND output is ignored.
- A supplier load in the same cycle as a dispense is ignored, because the block is not in IDLE.
- Decrementing count never underflows, because a slot with count 0 is always rejected as SOLD_OUT.

## Configuration
- VM2002_TIMEOUT_EN defined: the 512-cycle timer and the REFUND path are built.
- VM2002_TIMEOUT_EN undefined: no timer is built. COLLECT is left only by a dispense or a reset, and status never reaches 3.

## Test plan
- Load: item = 2, count = 3, cost = 30, valid pulse. Then buttons = 2 → info = 30.
- Purchase: coins 25 then 10, then select with buttons = 2 → status DISPENSE, product 2, balance 5 for one cycle, then IDLE. count[2] = 2.
- Insufficient: coins 25, then select slot 2 (cost 30) → INSUFFICIENT for 1 cycle, then COLLECT, balance 25. A further coin 5 plus select → DISPENSE, balance 0.
- Sold out: empty slot 5, coin 10, select slot 5 → SOLD_OUT, balance stays 10.
- Timeout (with VM2002_TIMEOUT_EN): coin 10, then 512 idle cycles → REFUND, balance 10, then IDLE balance 0. A coin at cycle 500 restarts the count.
- Resets: hrst mid-COLLECT → all outputs 0 and inventory cleared. srst mid-COLLECT → IDLE with inventory intact.
